// File: rtl/wb_arbiter_pkg.sv
// Shared constants and types for the write-back arbiter.
package wb_arbiter_pkg;

    localparam int unsigned DEFAULT_ADDR_WIDTH = 5;
    localparam int unsigned DEFAULT_DATA_WIDTH = 32;

    // Output slot occupancy
    typedef enum logic {
        EMPTY = 1'b0,
        FULL  = 1'b1
    } slot_state_e;

endpackage

// File: rtl/wb_arbiter_rr_arb2.sv
// Two-requester round-robin grant. ptr holds the index of the last granted
// requester; on contention the other requester wins.
module rr_arb2 (
    input  logic [1:0] valid,
    input  logic       ptr,
    output logic [1:0] grant
);

    // One-hot grant from the valid pair and the round-robin pointer
    always_comb begin
        grant = 2'b00;
        case (valid)
            2'b01:   grant = 2'b01;
            2'b10:   grant = 2'b10;
            2'b11:   grant = ptr ? 2'b01 : 2'b10;
            default: grant = 2'b00;
        endcase
    end

endmodule

// File: rtl/wb_arbiter.sv
// Write-back arbiter: grants one of two requesters into a single-entry output
// slot that drains into the register file. Writes to address 0 drain silently.
// Optional read bypass from the slot is enabled by defining WB_ARBITER_BYPASS_EN.
module wb_arbiter
    import wb_arbiter_pkg::*;
#(
    parameter int unsigned ADDR_WIDTH = DEFAULT_ADDR_WIDTH,
    parameter int unsigned DATA_WIDTH = DEFAULT_DATA_WIDTH
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  req0_valid,
    output logic                  req0_ready,
    input  logic [ADDR_WIDTH-1:0] req0_addr,
    input  logic [DATA_WIDTH-1:0] req0_data,
    input  logic                  req1_valid,
    output logic                  req1_ready,
    input  logic [ADDR_WIDTH-1:0] req1_addr,
    input  logic [DATA_WIDTH-1:0] req1_data,
    input  logic                  rf_stall,
    input  logic                  flush,
    output logic                  rf_wen,
    output logic [ADDR_WIDTH-1:0] rf_waddr,
    output logic [DATA_WIDTH-1:0] rf_wdata,
    input  logic [ADDR_WIDTH-1:0] rd_addr,
    output logic                  rd_hit,
    output logic [DATA_WIDTH-1:0] rd_data
);

    slot_state_e           state_q;
    logic [ADDR_WIDTH-1:0] addr_q;
    logic [DATA_WIDTH-1:0] data_q;
    logic                  ptr_q;

    logic [1:0] grant;
    logic       slot_full;
    logic       retire;
    logic       accept_ok;
    logic       accept;

    rr_arb2 u_rr_arb2 (
        .valid ({req1_valid, req0_valid}),
        .ptr   (ptr_q),
        .grant (grant)
    );

    assign slot_full = (state_q == FULL);
    assign retire    = slot_full & ~rf_stall;
    // Slot can take a new write if it is empty or draining this cycle
    assign accept_ok = ~rst & ~flush & (~slot_full | retire);

    assign req0_ready = grant[0] & accept_ok;
    assign req1_ready = grant[1] & accept_ok;
    assign accept     = req0_ready | req1_ready;

    assign rf_wen   = retire & ~flush & ~rst & (addr_q != '0);
    assign rf_waddr = addr_q;
    assign rf_wdata = data_q;

    // Slot state, slot contents and round-robin pointer
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= EMPTY;
            addr_q  <= '0;
            data_q  <= '0;
            ptr_q   <= 1'b1;
        end else if (flush) begin
            state_q <= EMPTY;
        end else if (accept) begin
            state_q <= FULL;
            addr_q  <= grant[1] ? req1_addr : req0_addr;
            data_q  <= grant[1] ? req1_data : req0_data;
            ptr_q   <= grant[1];
        end else if (retire) begin
            state_q <= EMPTY;
        end
    end

`ifdef WB_ARBITER_BYPASS_EN
    assign rd_hit  = slot_full & ~rst & (rd_addr == addr_q) & (rd_addr != '0);
    assign rd_data = rd_hit ? data_q : '0;
`else
    logic unused_rd_addr;
    assign unused_rd_addr = ^rd_addr;
    assign rd_hit         = 1'b0;
    assign rd_data        = '0;
`endif

endmodule

// File: tb/tb_wb_arbiter.sv
// Self-checking bench for wb_arbiter: a vector table for the cycle-by-cycle
// behaviour plus a scoreboard of expected register-file writes.
module tb_wb_arbiter;

`ifdef WB_ARBITER_BYPASS_EN
    localparam bit Byp = 1'b1;
`else
    localparam bit Byp = 1'b0;
`endif

    logic        clk;
    logic        rst;
    logic        req0_valid, req1_valid;
    logic        req0_ready, req1_ready;
    logic [4:0]  req0_addr, req1_addr;
    logic [31:0] req0_data, req1_data;
    logic        rf_stall, flush;
    logic        rf_wen;
    logic [4:0]  rf_waddr;
    logic [31:0] rf_wdata;
    logic [4:0]  rd_addr;
    logic        rd_hit;
    logic [31:0] rd_data;

    wb_arbiter dut (
        .clk        (clk),
        .rst        (rst),
        .req0_valid (req0_valid),
        .req0_ready (req0_ready),
        .req0_addr  (req0_addr),
        .req0_data  (req0_data),
        .req1_valid (req1_valid),
        .req1_ready (req1_ready),
        .req1_addr  (req1_addr),
        .req1_data  (req1_data),
        .rf_stall   (rf_stall),
        .flush      (flush),
        .rf_wen     (rf_wen),
        .rf_waddr   (rf_waddr),
        .rf_wdata   (rf_wdata),
        .rd_addr    (rd_addr),
        .rd_hit     (rd_hit),
        .rd_data    (rd_data)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        logic        rst, flush, stall;
        logic        v0;
        logic [4:0]  a0;
        logic [31:0] d0;
        logic        v1;
        logic [4:0]  a1;
        logic [31:0] d1;
        logic [4:0]  rda;
        logic        r0, r1, wen, hit;
        logic [31:0] hd;
    } vec_t;

    typedef struct {
        logic [4:0]  a;
        logic [31:0] d;
    } wr_t;

    vec_t vecs[$];
    wr_t  sb[$];
    int   checks = 0;
    int   errors = 0;

    function automatic void add(input logic rs, input logic fl, input logic st,
                                input logic v0, input logic [4:0] a0, input logic [31:0] d0,
                                input logic v1, input logic [4:0] a1, input logic [31:0] d1,
                                input logic [4:0] rda, input logic r0, input logic r1,
                                input logic wen, input logic hit, input logic [31:0] hd);
        vec_t v;
        v.rst = rs; v.flush = fl; v.stall = st;
        v.v0 = v0; v.a0 = a0; v.d0 = d0;
        v.v1 = v1; v.a1 = a1; v.d1 = d1;
        v.rda = rda; v.r0 = r0; v.r1 = r1; v.wen = wen; v.hit = hit; v.hd = hd;
        vecs.push_back(v);
    endfunction

    task automatic cmp(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    // Compare one cycle's outputs; drain/fill the write scoreboard
    task automatic check_cycle(input string tag, input logic r0, input logic r1,
                               input logic wen, input logic hit, input logic [31:0] hd,
                               input logic drop);
        wr_t  w;
        logic exp_hit;
        exp_hit = hit & Byp;
        cmp({tag, " req0_ready"}, {31'b0, req0_ready}, {31'b0, r0});
        cmp({tag, " req1_ready"}, {31'b0, req1_ready}, {31'b0, r1});
        cmp({tag, " rf_wen"}, {31'b0, rf_wen}, {31'b0, wen});
        cmp({tag, " rd_hit"}, {31'b0, rd_hit}, {31'b0, exp_hit});
        cmp({tag, " rd_data"}, rd_data, exp_hit ? hd : 32'h0);
        if (rf_wen === 1'b1) begin
            if (sb.size() == 0) begin
                checks++;
                errors++;
                $display("FAIL %s unexpected write: got addr %0d expected none", tag, rf_waddr);
            end else begin
                w = sb.pop_front();
                cmp({tag, " rf_waddr"}, {27'b0, rf_waddr}, {27'b0, w.a});
                cmp({tag, " rf_wdata"}, rf_wdata, w.d);
            end
        end
        if (r0 && req0_addr != 5'd0) begin
            w.a = req0_addr; w.d = req0_data; sb.push_back(w);
        end
        if (r1 && req1_addr != 5'd0) begin
            w.a = req1_addr; w.d = req1_data; sb.push_back(w);
        end
        if (drop) sb.delete();
    endtask

    task automatic drive(input vec_t v);
        rst = v.rst; flush = v.flush; rf_stall = v.stall;
        req0_valid = v.v0; req0_addr = v.a0; req0_data = v.d0;
        req1_valid = v.v1; req1_addr = v.a1; req1_data = v.d1;
        rd_addr = v.rda;
    endtask

    initial begin
        vec_t        v;
        logic [31:0] rnd;
        bit          seen;

        // rst fl st  v0 a0 d0          v1 a1 d1          rda  r0 r1 wen hit hd
        add(1, 0, 0,  1, 1, 32'hA1,     1, 2, 32'hB2,     0,   0, 0, 0, 0, 0);   // reset
        add(0, 0, 0,  1, 1, 32'hA1,     1, 2, 32'hB2,     0,   1, 0, 0, 0, 0);   // contention
        add(0, 0, 0,  1, 1, 32'hA1,     1, 2, 32'hB2,     0,   0, 1, 1, 0, 0);
        add(0, 0, 0,  1, 1, 32'hA1,     1, 2, 32'hB2,     0,   1, 0, 1, 0, 0);
        add(0, 0, 0,  1, 1, 32'hA1,     1, 2, 32'hB2,     0,   0, 1, 1, 0, 0);
        add(0, 0, 0,  0, 0, 0,          0, 0, 0,          0,   0, 0, 1, 0, 0);
        add(0, 0, 0,  1, 5, 32'h1234,   0, 0, 0,          0,   1, 0, 0, 0, 0);   // single
        add(0, 0, 0,  0, 0, 0,          0, 0, 0,          0,   0, 0, 1, 0, 0);
        add(0, 0, 0,  0, 0, 0,          1, 3, 32'h33,     0,   0, 1, 0, 0, 0);   // stall
        add(0, 0, 1,  1, 4, 32'h44,     0, 0, 0,          0,   0, 0, 0, 0, 0);
        add(0, 0, 1,  1, 4, 32'h44,     0, 0, 0,          0,   0, 0, 0, 0, 0);
        add(0, 0, 1,  1, 4, 32'h44,     0, 0, 0,          0,   0, 0, 0, 0, 0);
        add(0, 0, 0,  1, 4, 32'h44,     0, 0, 0,          0,   1, 0, 1, 0, 0);
        add(0, 0, 0,  0, 0, 0,          0, 0, 0,          0,   0, 0, 1, 0, 0);
        add(0, 0, 0,  0, 0, 0,          1, 0, 32'hFFFF,   0,   0, 1, 0, 0, 0);   // x0
        add(0, 0, 0,  1, 6, 32'h66,     0, 0, 0,          0,   1, 0, 0, 0, 0);
        add(0, 0, 0,  0, 0, 0,          0, 0, 0,          0,   0, 0, 1, 0, 0);
        add(0, 0, 0,  1, 7, 32'h77,     0, 0, 0,          0,   1, 0, 0, 0, 0);   // flush
        add(0, 1, 0,  0, 0, 0,          1, 8, 32'h88,     0,   0, 0, 0, 0, 0);
        add(0, 0, 0,  0, 0, 0,          0, 0, 0,          0,   0, 0, 0, 0, 0);
        add(0, 0, 0,  1, 7, 32'h77,     0, 0, 0,          0,   1, 0, 0, 0, 0);   // reset mid-stall
        add(1, 0, 1,  0, 0, 0,          0, 0, 0,          0,   0, 0, 0, 0, 0);
        add(0, 0, 0,  0, 0, 0,          0, 0, 0,          0,   0, 0, 0, 0, 0);
        add(0, 0, 0,  1, 1, 32'hA1,     1, 2, 32'hB2,     0,   1, 0, 0, 0, 0);   // ptr back to 1
        add(0, 1, 1,  1, 1, 32'hA1,     1, 2, 32'hB2,     0,   0, 0, 0, 0, 0);   // flush+stall
        add(0, 0, 0,  1, 1, 32'hA1,     1, 2, 32'hB2,     0,   0, 1, 0, 0, 0);   // ptr kept
        add(0, 0, 0,  0, 0, 0,          0, 0, 0,          0,   0, 0, 1, 0, 0);
        add(0, 0, 0,  1, 9, 32'hAB,     0, 0, 0,          0,   1, 0, 0, 0, 0);   // bypass
        add(0, 0, 1,  0, 0, 0,          0, 0, 0,          9,   0, 0, 0, 1, 32'hAB);
        add(0, 0, 1,  0, 0, 0,          0, 0, 0,          0,   0, 0, 0, 0, 0);
        add(0, 0, 0,  0, 0, 0,          0, 0, 0,          9,   0, 0, 1, 1, 32'hAB);
        add(0, 0, 0,  0, 0, 0,          0, 0, 0,          9,   0, 0, 0, 0, 0);

        // Initial reset cycle before the table
        v = vecs[0];
        drive(v);
        @(posedge clk);

        for (int i = 0; i < vecs.size(); i++) begin
            #1;
            drive(vecs[i]);
            #4;
            check_cycle($sformatf("row%0d", i), vecs[i].r0, vecs[i].r1, vecs[i].wen,
                        vecs[i].hit, vecs[i].hd, vecs[i].rst | vecs[i].flush);
            @(posedge clk);
        end

        // Long stall with random data, then a bounded wait for the drain
        rnd = $urandom;
        #1;
        v = vecs[vecs.size() - 1];
        v.rda = 0; v.v1 = 1; v.a1 = 5'd10; v.d1 = rnd;
        drive(v);
        #4;
        check_cycle("seq accept", 1'b0, 1'b1, 1'b0, 1'b0, 32'h0, 1'b0);
        @(posedge clk);
        for (int i = 0; i < 2; i++) begin
            #1;
            req1_valid = 1'b0;
            rf_stall   = 1'b1;
            #4;
            check_cycle($sformatf("seq stall%0d", i), 1'b0, 1'b0, 1'b0, 1'b0, 32'h0, 1'b0);
            @(posedge clk);
        end
        #1;
        rf_stall = 1'b0;
        seen = 1'b0;
        for (int i = 0; i < 4 && !seen; i++) begin
            #4;
            if (rf_wen === 1'b1) begin
                seen = 1'b1;
                check_cycle("seq drain", 1'b0, 1'b0, 1'b1, 1'b0, 32'h0, 1'b0);
            end
            @(posedge clk);
            #1;
        end
        checks++;
        if (!seen) begin
            errors++;
            $display("FAIL seq drain timeout: got no rf_wen expected one within 4 cycles");
        end

        cmp("scoreboard empty", sb.size(), 32'd0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
